// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: state encodings,
// default lock bound and the per-port request bundle.
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_G0   = 2'd1,
    ARB_G1   = 2'd2
  } arb_state_e;

  localparam int LOCK_MAX_DEF = 16;
  localparam int CNT_W_DEF    = 8;

  // One requester's view of the bus, muxed as a unit onto the memory.
  typedef struct packed {
    logic        req;
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } port_req_t;

  // Map a port index onto its grant state.
  function automatic arb_state_e grant_of(input logic idx);
    return idx ? ARB_G1 : ARB_G0;
  endfunction

endpackage

// File: rtl/dm_lock_timer.sv
// Bus-lock watchdog: counts locked cycles and flags the final allowed one.
module dm_lock_timer
  import dm_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LOCK_MAX - 1);

  logic [CNT_W-1:0] lcnt;

  // Saturating up-counter; clear wins over enable so a fresh lock starts at 0.
  always_ff @(posedge clk) begin
    if (reset || clear)
      lcnt <= '0;
    else if (enable && (lcnt != LAST))
      lcnt <= lcnt + 1'b1;
  end

  assign expire = (lcnt == LAST);

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter for the single-port data memory with req/ack
// handshake and a bounded read-modify-write bus lock.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic        r0_lock,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [31:0] r0_pc,
  output logic        r0_ack,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic        r1_lock,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [31:0] r1_pc,
  output logic        r1_ack,
  output logic [31:0] r1_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_pc,
  output logic        dm_we,
  input  logic [31:0] dm_rdata,
  output logic        lock_abort
);

  arb_state_e state, state_nxt;
  logic       locked, locked_nxt;
  logic       rr, rr_nxt;
  logic       abort_q, abort_nxt;
  logic       lock_clear;
  logic       expire;

  port_req_t  prt [2];
  port_req_t  own, oth;
  logic       gidx;

  assign prt[0] = '{req: r0_req, we: r0_we, lock: r0_lock,
                    addr: r0_addr, wdata: r0_wdata, pc: r0_pc};
  assign prt[1] = '{req: r1_req, we: r1_we, lock: r1_lock,
                    addr: r1_addr, wdata: r1_wdata, pc: r1_pc};

  assign gidx = (state == ARB_G1);
  assign own  = prt[gidx];
  assign oth  = prt[~gidx];

  dm_lock_timer #(
    .LOCK_MAX (LOCK_MAX),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (lock_clear),
    .enable (locked),
    .expire (expire)
  );

  // State, lock flag, round-robin pointer and abort pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB_IDLE;
      locked  <= 1'b0;
      rr      <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      locked  <= locked_nxt;
      rr      <= rr_nxt;
      abort_q <= abort_nxt;
    end
  end

  // Next-state: grant selection, lock entry/exit and forced release.
  // The acked port's own req is never looked at when choosing the next
  // grant, so a held req costs an IDLE cycle unless the other port is waiting.
  always_comb begin
    state_nxt  = state;
    locked_nxt = locked;
    rr_nxt     = rr;
    abort_nxt  = 1'b0;
    lock_clear = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (r0_req && r1_req)
          state_nxt = grant_of(rr);
        else if (r0_req || r1_req)
          state_nxt = grant_of(r1_req);
      end
      ARB_G0, ARB_G1: begin
        if (!locked) begin
          if (own.req && own.lock) begin
            locked_nxt = 1'b1;
            lock_clear = 1'b1;
          end else begin
            rr_nxt    = ~gidx;
            state_nxt = oth.req ? grant_of(~gidx) : ARB_IDLE;
          end
        end else if (own.req && !own.lock) begin
          // Normal release takes priority over a coinciding timeout.
          locked_nxt = 1'b0;
          rr_nxt     = ~gidx;
          state_nxt  = oth.req ? grant_of(~gidx) : ARB_IDLE;
        end else if (!own.req && !own.lock) begin
          locked_nxt = 1'b0;
          rr_nxt     = ~gidx;
          state_nxt  = ARB_IDLE;
        end else if (expire) begin
          // Forced release; an ack in this cycle still completes.
          locked_nxt = 1'b0;
          rr_nxt     = ~gidx;
          abort_nxt  = 1'b1;
          state_nxt  = oth.req ? grant_of(~gidx) : ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Data-path mux; write enable and acks are suppressed while in reset.
  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_pc    = '0;
    dm_we    = 1'b0;
    r0_ack   = 1'b0;
    r1_ack   = 1'b0;
    r0_rdata = '0;
    r1_rdata = '0;
    if (state == ARB_G0 || state == ARB_G1) begin
      dm_addr  = own.addr;
      dm_wdata = own.wdata;
      dm_pc    = own.pc;
      dm_we    = own.we && own.req && !reset;
    end
    if (state == ARB_G0) begin
      r0_ack   = r0_req && !reset;
      r0_rdata = dm_rdata;
    end
    if (state == ARB_G1) begin
      r1_ack   = r1_req && !reset;
      r1_rdata = dm_rdata;
    end
  end

  assign lock_abort = abort_q && !reset;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small behavioural data memory.
module tb_dm_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [31:0] r0_addr, r0_wdata, r0_pc, r1_addr, r1_wdata, r1_pc;
  logic        r0_ack, r1_ack, dm_we, lock_abort;
  logic [31:0] r0_rdata, r1_rdata, dm_addr, dm_wdata, dm_pc, dm_rdata;
  logic        mem_clr;
  logic [31:0] mem [64];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.LOCK_MAX(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_pc(r0_pc), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_pc(r1_pc), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_pc(dm_pc), .dm_we(dm_we),
    .dm_rdata(dm_rdata), .lock_abort(lock_abort)
  );

  assign dm_rdata = mem[dm_addr[7:2]];

  // Memory model: combinational read, write at the rising edge.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (dm_we) begin
      mem[dm_addr[7:2]] <= dm_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; mem_clr = 1'b1;
    r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = 0; r0_wdata = 0; r0_pc = 0;
    r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = 0; r1_wdata = 0; r1_pc = 0;
    tick(); tick();
    mem_clr = 1'b0;
    #1;
    chk("rst_ack0", {31'd0, r0_ack}, 0);
    chk("rst_dmwe", {31'd0, dm_we}, 0);

    // Reset asserted during GRANT0 with a pending store.
    reset = 1'b0;
    r0_req = 1; r0_we = 1; r0_addr = 32'h40; r0_wdata = 32'hDEAD_BEEF; r0_pc = 32'h100;
    #1;
    chk("idle_ack", {31'd0, r0_ack}, 0);
    tick();                                   // now GRANT0
    reset = 1'b1;
    #1;
    chk("rst_g0_we", {31'd0, dm_we}, 0);
    chk("rst_g0_ack", {31'd0, r0_ack}, 0);
    tick();                                   // reset sampled -> IDLE
    #1;
    chk("rst2_we", {31'd0, dm_we}, 0);
    chk("rst2_ack", {31'd0, r0_ack}, 0);
    r0_req = 0; reset = 1'b0;
    tick();
    #1;
    chk("post_addr", dm_addr, 0);
    chk("post_wdata", dm_wdata, 0);
    chk("post_pc", dm_pc, 0);
    chk("post_we", {31'd0, dm_we}, 0);
    chk("post_abort", {31'd0, lock_abort}, 0);
    chk("post_rdata", r0_rdata, 0);
    chk("no_write", mem[16], 0);

    // Single store then load.
    r0_req = 1; r0_we = 1; r0_addr = 32'h10; r0_wdata = 32'h1234_5678; r0_pc = 32'h3000;
    #1;
    chk("st_idle_ack", {31'd0, r0_ack}, 0);
    chk("st_idle_we", {31'd0, dm_we}, 0);
    tick();
    chk("st_ack", {31'd0, r0_ack}, 1);
    chk("st_we", {31'd0, dm_we}, 1);
    chk("st_addr", dm_addr, 32'h10);
    chk("st_wdata", dm_wdata, 32'h1234_5678);
    chk("st_pc", dm_pc, 32'h3000);
    tick();
    r0_we = 0;
    #1;
    chk("ld_idle_ack", {31'd0, r0_ack}, 0);
    chk("ld_idle_we", {31'd0, dm_we}, 0);
    tick();
    chk("ld_ack", {31'd0, r0_ack}, 1);
    chk("ld_we", {31'd0, dm_we}, 0);
    chk("ld_rdata", r0_rdata, 32'h1234_5678);
    tick();
    r0_req = 0;

    // Contention right after reset: r0, r1, r0.
    reset = 1'b1; tick(); reset = 1'b0;
    r0_req = 1; r0_we = 0; r0_addr = 32'h10;
    r1_req = 1; r1_we = 0; r1_addr = 32'h10;
    tick();
    chk("ct1_r0", {31'd0, r0_ack}, 1);
    chk("ct1_r1", {31'd0, r1_ack}, 0);
    tick();
    chk("ct2_r0", {31'd0, r0_ack}, 0);
    chk("ct2_r1", {31'd0, r1_ack}, 1);
    chk("ct2_rd", r1_rdata, 32'h1234_5678);
    tick();
    r1_req = 0;
    #1;
    chk("ct3_r0", {31'd0, r0_ack}, 1);
    chk("ct3_r1", {31'd0, r1_ack}, 0);
    tick();                                   // IDLE, rr -> port 1
    r0_req = 0;

    // Lock: r1 holds the bus for 4 transactions while r0 waits.
    r0_req = 1; r0_we = 0; r0_addr = 32'h10;
    r1_req = 1; r1_we = 1; r1_lock = 1; r1_addr = 32'h20; r1_wdata = 32'hA1;
    tick();
    chk("lk1_r1", {31'd0, r1_ack}, 1);
    chk("lk1_r0", {31'd0, r0_ack}, 0);
    tick();
    r1_addr = 32'h24; r1_wdata = 32'hA2;
    #1;
    chk("lk2_r1", {31'd0, r1_ack}, 1);
    chk("lk2_r0", {31'd0, r0_ack}, 0);
    tick();
    r1_addr = 32'h28; r1_wdata = 32'hA3;
    #1;
    chk("lk3_r1", {31'd0, r1_ack}, 1);
    chk("lk3_r0", {31'd0, r0_ack}, 0);
    tick();
    r1_addr = 32'h2C; r1_wdata = 32'hA4; r1_lock = 0;
    #1;
    chk("lk4_r1", {31'd0, r1_ack}, 1);
    chk("lk4_r0", {31'd0, r0_ack}, 0);
    chk("lk4_addr", dm_addr, 32'h2C);
    tick();
    r1_req = 0; r1_we = 0;
    #1;
    chk("lk5_r0", {31'd0, r0_ack}, 1);
    chk("lk5_r1", {31'd0, r1_ack}, 0);
    chk("lk5_rd", r0_rdata, 32'h1234_5678);
    chk("lk5_abort", {31'd0, lock_abort}, 0);
    chk("lk_mem", mem[10], 32'hA3);
    tick();
    r0_req = 0;

    // Lock timeout: r0 locks then idles with lock held.
    r0_req = 1; r0_we = 1; r0_lock = 1; r0_addr = 32'h30; r0_wdata = 32'hB0;
    tick();
    chk("to_ack", {31'd0, r0_ack}, 1);
    tick();
    r0_req = 0;
    r1_req = 1; r1_we = 0; r1_addr = 32'h30;
    #1;
    chk("to_b_r1", {31'd0, r1_ack}, 0);
    chk("to_b_we", {31'd0, dm_we}, 0);
    chk("to_b_abort", {31'd0, lock_abort}, 0);
    tick();
    chk("to_c_r1", {31'd0, r1_ack}, 0);
    tick();
    chk("to_d_r1", {31'd0, r1_ack}, 0);
    tick();
    chk("to_e_r1", {31'd0, r1_ack}, 0);
    chk("to_e_abort", {31'd0, lock_abort}, 0);
    tick();
    chk("to_f_r1", {31'd0, r1_ack}, 1);
    chk("to_f_abort", {31'd0, lock_abort}, 1);
    chk("to_f_rd", r1_rdata, 32'hB0);
    tick();
    r1_req = 0; r0_lock = 0;
    #1;
    chk("to_g_abort", {31'd0, lock_abort}, 0);
    chk("to_g_r1", {31'd0, r1_ack}, 0);

    // Held req with no competitor: acked every other cycle.
    r0_req = 1; r0_we = 0; r0_addr = 32'h10;
    #1;
    chk("hold0", {31'd0, r0_ack}, 0);
    tick();
    chk("hold1", {31'd0, r0_ack}, 1);
    tick();
    chk("hold2", {31'd0, r0_ack}, 0);
    tick();
    chk("hold3", {31'd0, r0_ack}, 1);
    tick();
    chk("hold4", {31'd0, r0_ack}, 0);
    r0_req = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
